dmem_responder: RTL

- Data-memory responder for the CPU's MEM-stage requests: byte address, store data, read/write strobe, funct3 size control.
- Owns a synchronous word-organised RAM and performs byte-lane steering, sign/zero extension and bounds checking.
- Returns one response per request over a valid/ready handshake.
- Sits between the MEM stage (initiator) and on-chip data storage.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM
// state encoding and byte-lane mask helpers.
package dmem_pkg;

  localparam logic [2:0] MEM_B   = 3'b000;
  localparam logic [2:0] MEM_H   = 3'b001;
  localparam logic [2:0] MEM_W   = 3'b010;
  localparam logic [2:0] MEM_D   = 3'b011;
  localparam logic [2:0] MEM_BU  = 3'b100;
  localparam logic [2:0] MEM_HU  = 3'b101;
  localparam logic [2:0] MEM_WU  = 3'b110;
  localparam logic [2:0] MEM_BAD = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } state_e;

  // Byte enables across two consecutive words: bits [7:0] hit the first word,
  // bits [15:8] the following one.
  function automatic logic [15:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [15:0] base;
    unique case (size)
      2'd0:    base = 16'h0001;
      2'd1:    base = 16'h0003;
      2'd2:    base = 16'h000f;
      default: base = 16'h00ff;
    endcase
    return base << offset;
  endfunction

  // Low address bits that must be zero for a size-aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    unique case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised synchronous RAM with per-byte write enables, one write port
// and one registered read port. Contents are not reset.
module dmem_ram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 512
) (
  input  logic                       clk,
  input  logic [WIDTH/8-1:0]         we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Byte-lane writes and registered read
  always_ff @(posedge clk) begin
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage requests: byte-lane steering, sign/zero
// extension and bounds checking in front of a synchronous word RAM.
// Optional feature: define DMEM_MISALIGN_EN to split accesses that cross an
// 8-byte boundary over two RAM words; otherwise misaligned accesses error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 64,  // only 64 is supported
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_ctrl,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 3;  // byte-address bits that land inside the RAM

  state_e           state;
  logic [AW-1:0]    word_q;
  logic [2:0]       off_q;
  logic [2:0]       ctrl_q;
  logic             write_q;
  logic             split_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] hold_q;

  logic [3:0]       req_nbytes;
  logic [BW:0]      req_last;
  logic             req_oob;
  logic             req_split;
  logic             req_bad;

  logic [7:0]       ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  logic [5:0]         shamt;
  logic [15:0]        lane_mask;
  logic [2*WIDTH-1:0] wpair;
  logic [2*WIDTH-1:0] rpair;
  logic [WIDTH-1:0]   load_word;

  // Sign- or zero-extend the right-aligned load value by access size
  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] raw,
                                              input logic [2:0]       ctrl);
    logic fill;
    unique case (ctrl[1:0])
      2'd0: begin
        fill = ~ctrl[2] & raw[7];
        return {{(WIDTH-8){fill}}, raw[7:0]};
      end
      2'd1: begin
        fill = ~ctrl[2] & raw[15];
        return {{(WIDTH-16){fill}}, raw[15:0]};
      end
      2'd2: begin
        fill = ~ctrl[2] & raw[31];
        return {{(WIDTH-32){fill}}, raw[31:0]};
      end
      default: return raw;
    endcase
  endfunction

  // Classify the incoming request: bounds, split and error decisions
  always_comb begin
    req_nbytes = 4'd1 << req_ctrl[1:0];
    // Last byte touched; an overflow into bit BW means it lies past the RAM.
    req_last   = {1'b0, req_addr[BW-1:0]} + {{(BW-3){1'b0}}, req_nbytes - 4'd1};
    req_oob    = (|req_addr[WIDTH-1:BW]) || req_last[BW];
`ifdef DMEM_MISALIGN_EN
    req_split  = ({1'b0, req_addr[2:0]} + req_nbytes) > 4'd8;
    req_bad    = (req_ctrl == MEM_BAD) || req_oob;
`else
    req_split  = 1'b0;
    req_bad    = (req_ctrl == MEM_BAD) || req_oob ||
                 (|(req_addr[2:0] & size_mask(req_ctrl[1:0])));
`endif
  end

  // Byte-lane steering for stores, word assembly for loads, RAM port muxing
  always_comb begin
    shamt     = {off_q, 3'b000};
    lane_mask = be_mask(ctrl_q[1:0], off_q);
    wpair     = {{WIDTH{1'b0}}, wdata_q} << shamt;
    rpair     = (state == StAcc1) ? {ram_rdata, hold_q} : {{WIDTH{1'b0}}, ram_rdata};
    load_word = WIDTH'(rpair >> shamt);
    // Read is issued one cycle ahead: the request word while idle, word+1 in ACC0.
    ram_raddr = (state == StIdle) ? req_addr[BW-1:3] : word_q + AW'(1);
    ram_we    = '0;
    ram_waddr = word_q;
    ram_wdata = wpair[WIDTH-1:0];
    if (write_q && (state == StAcc0)) begin
      ram_we = lane_mask[7:0];
    end
    if (write_q && (state == StAcc1)) begin
      ram_we    = lane_mask[15:8];
      ram_waddr = word_q + AW'(1);
      ram_wdata = wpair[2*WIDTH-1:WIDTH];
    end
  end

  assign req_ready = (state == StIdle);

  // Request/response FSM with registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      word_q     <= '0;
      off_q      <= '0;
      ctrl_q     <= '0;
      write_q    <= 1'b0;
      split_q    <= 1'b0;
      wdata_q    <= '0;
      hold_q     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            word_q  <= req_addr[BW-1:3];
            off_q   <= req_addr[2:0];
            ctrl_q  <= req_ctrl;
            write_q <= req_write;
            wdata_q <= req_wdata;
            split_q <= req_split;
            if (req_bad) begin
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= StAcc0;
            end
          end
        end
        StAcc0: begin
          hold_q <= ram_rdata;
          if (split_q) begin
            state <= StAcc1;
          end else begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? '0 : extend(load_word, ctrl_q);
          end
        end
        // Reachable only when split accesses are enabled.
        StAcc1: begin
          state      <= StResp;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= write_q ? '0 : extend(load_word, ctrl_q);
        end
        StResp: begin
          if (resp_ready) begin
            state      <= StIdle;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  dmem_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule
